// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues ALU commands in a small FIFO, issues them one at a
// time to a registered external ALU, and presents each result through a
// valid/ready handshake. Unsupported op codes bypass the ALU and return an
// error result.
module alu_cmd_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_sel,
  output logic        res_err,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int unsigned SW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned EW = SW + 2 * DW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  logic          empty;

  logic [EW-1:0] head;
  logic [SW-1:0] head_sel;
  logic [DW-1:0] head_a;
  logic [DW-1:0] head_b;
  logic          head_legal;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic          ld_alu;
  logic          ld_res;
  logic          ld_err;
  logic          hs;

  // cmd_ready is a registered copy of !full, so a full FIFO never pushes
  assign push       = cmd_valid && cmd_ready;
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign head_sel   = head[EW-1 -: SW];
  assign head_a     = head[2*DW-1 -: DW];
  assign head_b     = head[DW-1:0];
  assign head_legal = (head_sel[3:2] == 2'b00);

  // FIFO storage write port (contents are don't-care while empty)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_sel, cmd_a, cmd_b};
    end
  end

  // FIFO occupancy after this edge
  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  // FIFO pointers and occupancy; power-of-two depth wraps pointers naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
    end
  end

  // FSM state and ALU latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // next-state decode; IDLE and an accepted RESULT both dispatch the FIFO head
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    pop       = 1'b0;
    ld_alu    = 1'b0;
    ld_res    = 1'b0;
    ld_err    = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            state_nxt = ISSUE;
            ld_alu    = 1'b1;
          end else begin
            state_nxt = RESULT;
            ld_err    = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        wait_nxt  = '0;
      end
      WAIT: begin
        if (wait_cnt == WW'(ALU_LAT - 1)) begin
          state_nxt = RESULT;
          ld_res    = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      RESULT: begin
        if (res_ready) begin
          hs = 1'b1;
          if (empty) begin
            state_nxt = IDLE;
          end else begin
            pop = 1'b1;
            if (head_legal) begin
              state_nxt = ISSUE;
              ld_alu    = 1'b1;
            end else begin
              state_nxt = RESULT;
              ld_err    = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // registered outputs: ALU operands, result payload, status and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_data  <= '0;
      res_sel   <= '0;
      res_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      cmd_ready <= (count_nxt != CW'(FIFO_DEPTH));
      busy      <= (state_nxt != IDLE) || (count_nxt != '0);
      res_valid <= (state_nxt == RESULT);
      if (ld_alu) begin
        alu_a   <= head_a;
        alu_b   <= head_b;
        alu_sel <= head_sel;
      end
      if (ld_res) begin
        res_data <= alu_out;
        res_sel  <= alu_sel;
        res_err  <= 1'b0;
      end else if (ld_err) begin
        res_data <= '0;
        res_sel  <= head_sel;
        res_err  <= 1'b1;
      end
      if (hs) op_count <= op_count + 16'd1;
    end
  end

endmodule
